// File: rtl/uart_tx_arbiter.sv
// 4-requester round-robin arbiter feeding a UART transmitter.
// Frame: start(0), 8 data bits LSB first, even parity, stop(1); each bit CLKS_PER_BIT cycles.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   req        - level request per requester 0..3
//   req_data   - byte for requester i on [8i+7:8i]
//   gnt        - one-hot 1-cycle pulse, requester whose byte was accepted
//   u_tx       - registered serial line, idle high
//   busy       - high while a frame is on u_tx
//   active_id  - owner of the current or most recent frame
//   tx_done    - 1-cycle pulse at frame end
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  gnt,
  output logic        u_tx,
  output logic        busy,
  output logic [1:0]  active_id,
  output logic        tx_done
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e           state_q;
  logic [BaudW-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic [1:0]       ptr_q;

  // Round-robin search starting at ptr_q (one past the last winner).
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic [7:0] win_byte;

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_byte = req_data[{win_idx, 3'b000} +: 8];
  end

  logic baud_last;
  assign baud_last = (baud_q == BaudLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      ptr_q     <= '0;
      gnt       <= '0;
      u_tx      <= 1'b1;
      busy      <= 1'b0;
      active_id <= '0;
      tx_done   <= 1'b0;
    end else begin
      gnt     <= '0;
      tx_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            shift_q   <= win_byte;
            parity_q  <= ^win_byte;
            active_id <= win_idx;
            gnt       <= 4'b0001 << win_idx;
            ptr_q     <= win_idx + 2'd1;
            u_tx      <= 1'b0;
            busy      <= 1'b1;
            baud_q    <= '0;
            state_q   <= StStart;
          end
        end
        StStart: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            u_tx    <= shift_q[0];
            state_q <= StData;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          if (baud_last) begin
            baud_q <= '0;
            bit_q  <= bit_q + 3'd1;  // wraps 7 -> 0 on the last data bit
            if (bit_q == 3'd7) begin
              u_tx    <= parity_q;
              state_q <= StParity;
            end else begin
              // Shift so the next data bit sits at index 1 of the old value.
              shift_q <= {1'b0, shift_q[7:1]};
              u_tx    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StParity: begin
          if (baud_last) begin
            baud_q  <= '0;
            u_tx    <= 1'b1;
            state_q <= StStop;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StStop: begin
          if (baud_last) begin
            baud_q  <= '0;
            busy    <= 1'b0;
            tx_done <= 1'b1;
            state_q <= StIdle;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int Cpb   = 4;
  localparam int Frame = 11 * Cpb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        u_tx;
  logic        busy;
  logic [1:0]  active_id;
  logic        tx_done;

  uart_tx_arbiter #(.CLKS_PER_BIT(Cpb)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .u_tx      (u_tx),
    .busy      (busy),
    .active_id (active_id),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: m_t counts cycles into the frame (0 = idle line).
  int         m_t;
  int         m_ptr;
  logic [7:0] m_byte;
  logic [3:0] m_gnt;
  logic       m_done;
  logic [1:0] m_id;

  int         cyc;
  int         last_gnt_cyc;
  logic [3:0] gnt_log[$];
  int         gnt_cyc[$];

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic logic exp_tx();
    if (m_t == 0) return 1'b1;
    return frame_bit(m_byte, (m_t - 1) / Cpb);
  endfunction

  task automatic model_reset();
    m_t = 0; m_ptr = 0; m_byte = '0; m_gnt = '0; m_done = 1'b0; m_id = '0;
  endtask

  // Effect of one rising edge given the inputs held across it.
  task automatic model_edge(input logic [3:0] r, input logic [31:0] d);
    int w;
    bit found;
    m_gnt  = '0;
    m_done = 1'b0;
    if (m_t == 0) begin
      found = 0;
      w = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && r[(m_ptr + k) % 4]) begin
          found = 1;
          w = (m_ptr + k) % 4;
        end
      end
      if (found) begin
        m_byte = d[8*w +: 8];
        m_gnt  = 4'b0001 << w;
        m_id   = 2'(w);
        m_ptr  = (w + 1) % 4;
        m_t    = 1;
      end
    end else if (m_t == Frame) begin
      m_t    = 0;
      m_done = 1'b1;
    end else begin
      m_t++;
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [31:0] d);
    @(negedge clk);
    cyc++;
    check("gnt", 32'(gnt), 32'(m_gnt));
    check("u_tx", 32'(u_tx), 32'(exp_tx()));
    check("busy", 32'(busy), 32'(m_t != 0));
    check("tx_done", 32'(tx_done), 32'(m_done));
    check("active_id", 32'(active_id), 32'(m_id));
    if (tx_done) check("gnt_to_done", 32'(cyc - last_gnt_cyc), 32'(Frame));
    if (gnt != 0) begin
      gnt_log.push_back(gnt);
      gnt_cyc.push_back(cyc);
      last_gnt_cyc = cyc;
    end
    req      = r;
    req_data = d;
    model_edge(r, d);
  endtask

  task automatic send_one(input logic [1:0] id, input logic [7:0] b);
    logic [31:0] d;
    d = $urandom;
    d[8*id +: 8] = b;
    step(4'b0001 << id, d);
    for (int i = 0; i < Frame + 4; i++) step(4'b0000, $urandom);
  endtask

  initial begin
    int n;
    logic [3:0] r;
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    cyc = 0;
    last_gnt_cyc = 0;
    model_reset();
    #12;
    check("rst_u_tx", 32'(u_tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_id", 32'(active_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(4'b0000, $urandom);

    // Known bytes including both parity polarities.
    send_one(2'd0, 8'hA5);
    send_one(2'd0, 8'h07);
    send_one(2'd0, 8'h00);

    // Short pulse on requester 1 during a busy frame must be ignored.
    step(4'b0001, 32'h0000_00C3);
    for (int i = 0; i < 10; i++) step(4'b0000, $urandom);
    n = gnt_log.size();
    step(4'b0010, $urandom);
    for (int i = 0; i < 2 * Frame; i++) step(4'b0000, $urandom);
    check("pulse_no_gnt", 32'(gnt_log.size() - n), 32'd0);

    // Reset in the middle of a frame.
    step(4'b0001, $urandom);
    for (int i = 0; i < 100 && m_t != 20; i++) step(4'b0000, $urandom);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req = '0;
    #1;
    check("midrst_u_tx", 32'(u_tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(tx_done), 32'd0);
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_id", 32'(active_id), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(4'b1000, $urandom);
    for (int i = 0; i < Frame + 4; i++) step(4'b0000, $urandom);
    check("post_rst_gnt", 32'(gnt_log[gnt_log.size() - 1]), 32'h8);

    // All requesters held, then 0101 after requester 3.
    gnt_log.delete();
    gnt_cyc.delete();
    for (int i = 0; i < 4 * 45; i++) step(4'b1111, 32'h4433_2211);
    for (int i = 0; i < 100; i++) step(4'b0101, 32'h4433_2211);
    check("rr_count", 32'(gnt_log.size() >= 6), 32'd1);
    if (gnt_log.size() >= 6) begin
      logic [3:0] exp_seq[6];
      exp_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h4};
      for (int i = 0; i < 6; i++) check($sformatf("rr_gnt%0d", i), 32'(gnt_log[i]), 32'(exp_seq[i]));
      for (int i = 1; i < 6; i++)
        check($sformatf("rr_gap%0d", i), 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd45);
    end
    for (int i = 0; i < Frame + 4; i++) step(4'b0000, $urandom);

    // Randomized traffic.
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) r = 4'($urandom);
      step(r, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, giving clock cycles per serial bit; legal values are 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 4 bits: level request per requester 0..3.
REQ-005 The block SHALL have port req_data, input, 32 bits: byte for requester i on bits [8i+7:8i].
REQ-006 The block SHALL have port gnt, output, 4 bits: one-hot, 1-cycle pulse marking the requester whose byte was accepted.
REQ-007 The block SHALL have port u_tx, output, 1 bit: registered serial line, idle high.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a frame is on u_tx.
REQ-009 The block SHALL have port active_id, output, 2 bits: index of the requester owning the current or most recent frame.
REQ-010 The block SHALL have port tx_done, output, 1 bit: 1-cycle pulse at frame end.

Function
REQ-011 Frame format SHALL be: start bit 0, 8 data bits LSB first, parity bit = XOR of the 8 data bits (even parity), stop bit 1.
REQ-012 Every frame bit SHALL be held on u_tx for exactly CLKS_PER_BIT cycles; one frame SHALL last 11*CLKS_PER_BIT cycles.
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-014 Transitions: IDLE->START on an edge with |req; START->DATA, PARITY->STOP after CLKS_PER_BIT cycles; DATA->PARITY after 8 bit periods; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-015 On the IDLE edge that accepts a request, the block SHALL capture the winner's byte, set active_id, pulse gnt for that cycle only, drive u_tx low and busy high from the following cycle.
REQ-016 Arbitration SHALL be round-robin: after granting i, search order is i+1, i+2, i+3, i (mod 4); after reset, search order starts at 0.
REQ-017 A request deasserted before its gnt SHALL produce no frame; req and req_data changes during a frame SHALL not affect it.
REQ-018 On the STOP->IDLE edge, tx_done SHALL pulse for 1 cycle and busy SHALL fall; u_tx SHALL stay high.
REQ-019 No grant SHALL occur on the STOP->IDLE edge; with requests pending, the next frame SHALL start after exactly one idle-high cycle.
REQ-020 Bit counter SHALL count 0..7 and baud counter 0..CLKS_PER_BIT-1, each wrapping to 0 without overflow.
REQ-021 gnt SHALL never have more than one bit set, and SHALL be 0 whenever the FSM is not in IDLE.

Reset
REQ-022 While rst_n is low, asynchronously: state=IDLE, u_tx=1, busy=0, gnt=0, tx_done=0, active_id=0, round-robin pointer=0, all counters=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately with no tx_done and no gnt; after release, the first grant follows REQ-016 from requester 0.

Verification
REQ-024 CLKS_PER_BIT=4, req=0001, byte0=0xA5 -> gnt=0001 for 1 cycle; u_tx=0,1,0,1,0,0,1,0,1,0(parity),1, each 4 cycles; tx_done 44 cycles after gnt; active_id=0.
REQ-025 req=1111 held, bytes 0x11,0x22,0x33,0x44 -> grants in order 0,1,2,3; 45 cycles between successive gnt pulses.
REQ-026 After requester 3 is granted, req=0101 -> next gnt=0001, then gnt=0100.
REQ-027 Byte 0x07 -> parity bit 1; byte 0x00 -> parity bit 0; stop bit 1 in both cases.
REQ-028 rst_n low at cycle 20 of a frame -> u_tx=1 and busy=0 in the same cycle, no tx_done; after release, req=1000 -> gnt=1000 and a complete frame.
REQ-029 req=0010 pulsed for one cycle during a busy frame and low at frame end -> no gnt=0010 and no second frame.
